// File: rtl/sensor_cond.sv
// -----------------------------------------------------------------------------
// sensor_cond
//   Conditioning stage between the A2D SPI interface and the motor/assist
//   control logic. A free-running counter produces a one-clock sample tick;
//   on the edge ending that tick the four raw readings are folded into:
//     - a 4-sample exponential average of motor current
//     - a 32-sample exponential average of pedal torque
//     - a brake flag debounced over two consecutive samples
//     - a battery-low flag with hysteresis
//   Nothing but the sampling edge changes any output.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   batt       in  12   raw battery reading
//   curr       in  12   raw motor current reading
//   brake      in  12   raw brake lever reading
//   torque     in  12   raw pedal torque reading
//   smpl_tick  out  1   high for the one clock in which inputs are sampled
//   avg_curr   out 12   exponential average of curr (weight 1/4)
//   avg_torque out 12   exponential average of torque (weight 1/32)
//   brake_on   out  1   debounced brake applied
//   batt_low   out  1   battery low, with hysteresis
// -----------------------------------------------------------------------------
module sensor_cond #(
    parameter int unsigned SMPL_PERIOD = 1024,
    parameter logic [11:0] BRAKE_THRES = 12'h800,
    parameter logic [11:0] BATT_LOW    = 12'hA00,
    parameter logic [11:0] BATT_HYST   = 12'h040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] brake,
    input  logic [11:0] torque,
    output logic        smpl_tick,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        brake_on,
    output logic        batt_low
);

    localparam int unsigned     CNT_W    = $clog2(SMPL_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SMPL_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [13:0]      r_acc_c;
    logic [16:0]      r_acc_t;
    logic             r_seeded;
    logic [1:0]       r_brk_hist;
    logic             r_brake_on;
    logic             r_batt_low;

    logic             w_tick;
    logic [13:0]      w_acc_c_nxt;
    logic [16:0]      w_acc_t_nxt;
    logic             w_brk_above;
    logic [1:0]       w_hist_nxt;
    logic [12:0]      w_batt_rel;
    logic             w_batt_ok;
    logic             w_batt_below;

    assign w_tick = (r_cnt == CNT_LAST);

    // Leaky integrators: acc holds avg scaled by 2^k, so subtracting acc>>k
    // and adding the new sample is one step of avg += (x - avg) / 2^k.
    assign w_acc_c_nxt = r_acc_c - {2'b00, r_acc_c[13:2]} + {2'b00, curr};
    assign w_acc_t_nxt = r_acc_t - {5'b00000, r_acc_t[16:5]} + {5'b00000, torque};

    assign w_brk_above = (brake > BRAKE_THRES);
    assign w_hist_nxt  = {r_brk_hist[0], w_brk_above};

    // Release threshold formed in 13 bits so a large BATT_LOW cannot wrap.
    assign w_batt_rel   = {1'b0, BATT_LOW} + {1'b0, BATT_HYST};
    assign w_batt_ok    = ({1'b0, batt} >= w_batt_rel);
    assign w_batt_below = (batt < BATT_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_c    <= '0;
            r_acc_t    <= '0;
            r_seeded   <= 1'b0;
            r_brk_hist <= '0;
            r_brake_on <= 1'b0;
            r_batt_low <= 1'b0;
        end else if (w_tick) begin
            // First sample after reset loads the accumulators directly so the
            // averages start at the reading instead of ramping up from zero.
            if (!r_seeded) begin
                r_acc_c  <= {curr, 2'b00};
                r_acc_t  <= {torque, 5'b00000};
                r_seeded <= 1'b1;
            end else begin
                r_acc_c <= w_acc_c_nxt;
                r_acc_t <= w_acc_t_nxt;
            end

            // Decide on the updated history so the flag sets on the second
            // consecutive applied sample rather than one tick later.
            r_brk_hist <= w_hist_nxt;
            if (w_hist_nxt == 2'b11) begin
                r_brake_on <= 1'b1;
            end else if (w_hist_nxt == 2'b00) begin
                r_brake_on <= 1'b0;
            end

            if (!r_batt_low && w_batt_below) begin
                r_batt_low <= 1'b1;
            end else if (r_batt_low && w_batt_ok) begin
                r_batt_low <= 1'b0;
            end
        end
    end

    assign smpl_tick  = w_tick;
    assign avg_curr   = r_acc_c[13:2];
    assign avg_torque = r_acc_t[16:5];
    assign brake_on   = r_brake_on;
    assign batt_low   = r_batt_low;

endmodule
